// File: rtl/cordic_atan2.sv
// Iterative CORDIC vectoring engine: converts a signed (cos, sin) pair into a
// 16-bit phase (65536 = 2*pi) and an uncompensated magnitude, one micro-rotation per clock.
module cordic_atan2 #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_cos,
  input  logic [15:0] i_sin,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_ph,
  output logic [17:0] o_mag,
  output logic        o_valid
);

  localparam int unsigned XW = 18;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic [PW-1:0]        r_z;
  logic [CW-1:0]        r_cnt;
  logic                 r_zero;
  logic                 r_ready;
  logic                 r_valid;
  logic [PW-1:0]        r_ph;
  logic [XW-1:0]        r_mag;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_cos_neg;
  logic signed [XW-1:0] w_cos_ext;
  logic signed [XW-1:0] w_sin_ext;
  logic signed [XW-1:0] w_x_sh;
  logic signed [XW-1:0] w_y_sh;
  logic signed [XW-1:0] w_x_nxt;
  logic signed [XW-1:0] w_y_nxt;
  logic [PW-1:0]        w_ang;
  logic [PW-1:0]        w_z_nxt;

  // atan(2^-k) scaled to 65536 per turn
  function automatic logic [PW-1:0] atan_lut(input logic [3:0] k);
    logic [PW-1:0] a;
    case (k)
      4'd0:    a = 16'd8192;
      4'd1:    a = 16'd4836;
      4'd2:    a = 16'd2555;
      4'd3:    a = 16'd1297;
      4'd4:    a = 16'd651;
      4'd5:    a = 16'd326;
      4'd6:    a = 16'd163;
      4'd7:    a = 16'd81;
      4'd8:    a = 16'd41;
      4'd9:    a = 16'd20;
      4'd10:   a = 16'd10;
      4'd11:   a = 16'd5;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      4'd14:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

  assign w_accept  = i_valid && r_ready;
  assign w_last    = (r_cnt == CW'(ITER - 1));
  assign w_cos_ext = {{(XW-16){i_cos[15]}}, i_cos};
  assign w_sin_ext = {{(XW-16){i_sin[15]}}, i_sin};
  assign w_cos_neg = i_cos[15];

  // One micro-rotation driving y toward zero; the sign of y picks the direction
  assign w_x_sh  = r_x >>> r_cnt;
  assign w_y_sh  = r_y >>> r_cnt;
  assign w_ang   = atan_lut(4'(r_cnt));
  assign w_x_nxt = r_y[XW-1] ? (r_x - w_y_sh) : (r_x + w_y_sh);
  assign w_y_nxt = r_y[XW-1] ? (r_y + w_x_sh) : (r_y - w_x_sh);
  assign w_z_nxt = r_y[XW-1] ? (r_z - w_ang)  : (r_z + w_ang);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_ph    <= '0;
      r_mag   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        // Left half-plane vectors are rotated by pi so the iterations always converge
        r_state <= S_ROTATE;
        r_ready <= 1'b0;
        r_cnt   <= '0;
        r_zero  <= (i_cos == 16'd0) && (i_sin == 16'd0);
        if (w_cos_neg) begin
          r_x <= -w_cos_ext;
          r_y <= -w_sin_ext;
          r_z <= 16'd32768;
        end else begin
          r_x <= w_cos_ext;
          r_y <= w_sin_ext;
          r_z <= '0;
        end
      end else begin
        case (r_state)
          S_ROTATE: begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_z   <= w_z_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_ready <= 1'b1;
              r_valid <= 1'b1;
              r_ph    <= r_zero ? '0 : w_z_nxt;
              r_mag   <= r_zero ? '0 : XW'(w_x_nxt);
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_ph    = r_ph;
  assign o_mag   = r_mag;

endmodule
